uart_tx_port: RTL and testbench

- Memory-mapped 8N1 serial transmitter on the 65C02 data bus, clocked by the CPU clock.
- Sits beside the RAM and the LED io_port: top-level decode drives `sel`, and the CPU writes bytes into a small FIFO.
- A bit-serial engine drains the FIFO onto `tx`.
- Read data is registered, giving the same one-cycle read latency as the boot ROM and RAM, so top muxes `data_out` using its registered `io_addr`.

---
 rtl/uart_tx_port.sv | 103 ++++++++++
 tb/tb_uart_tx_port.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/uart_tx_port.sv
// uart_tx_port: memory-mapped 8N1 serial transmitter with a write FIFO for the 65C02 bus.
module uart_tx_port #(
  parameter int BAUD_DIV = 164,
  parameter int FIFO_AW  = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sel,
  input  logic [1:0] addr,
  input  logic       we,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       tx,
  output logic       irq
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
  localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(DEPTH);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic [7:0] mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0] count;
  logic [15:0] baud, baud_n;
  logic [2:0] bit_cnt, bit_n;
  logic [7:0] shift, shift_n, rdata;
  logic tx_n, irq_en, ovf, full, empty, busy, push, push_ok, pop, rd, last;
  assign full    = count == FULL_CNT;
  assign empty   = count == '0;
  assign busy    = state != IDLE;
  assign push    = sel && we && addr == 2'd0;
  assign push_ok = push && !full;
  assign pop     = state == IDLE && !empty;
  assign rd      = sel && !we;
  assign last    = baud == BAUD_LAST;
  assign rdata   = addr == 2'd1 ? {4'b0, ovf, empty, full, busy} :
                   addr == 2'd2 ? {7'b0, irq_en} : 8'h00;
  always_comb begin
    state_n = state;
    baud_n  = last ? '0 : baud + 16'd1;
    bit_n   = bit_cnt;
    shift_n = shift;
    tx_n    = 1'b1;
    case (state)
      IDLE: begin
        baud_n = '0;
        if (!empty) begin
          state_n = START;
          shift_n = mem[rd_ptr];
        end
      end
      START: begin
        tx_n = 1'b0;
        if (last) begin
          state_n = DATA;
          bit_n   = '0;
        end
      end
      DATA: begin
        tx_n = shift[0];
        if (last) begin
          shift_n = shift >> 1;
          bit_n   = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_n = STOP;
        end
      end
      STOP: if (last) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // tx is registered from the current state, so it trails each state change by one clock
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      baud     <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
      irq      <= 1'b0;
      irq_en   <= 1'b0;
      ovf      <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      data_out <= 8'h00;
    end else begin
      state   <= state_n;
      baud    <= baud_n;
      bit_cnt <= bit_n;
      shift   <= shift_n;
      tx      <= tx_n;
      irq     <= irq_en && empty && !busy;
      if (sel && we && addr == 2'd2) irq_en <= data_in[0];
      ovf <= (push && full) || (ovf && !(rd && addr == 2'd1));
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= (push_ok && !pop) ? count + 1'b1 :
               (pop && !push_ok) ? count - 1'b1 : count;
      if (rd) data_out <= rdata;
    end
  end
  always_ff @(posedge clk) if (push_ok) mem[wr_ptr] <= data_in;
endmodule

// File: tb/tb_uart_tx_port.sv
// tb_uart_tx_port: directed checks of the UART transmitter with BAUD_DIV=4.
module tb_uart_tx_port;
  logic clk = 1'b0, reset = 1'b0, sel = 1'b0, we = 1'b0;
  logic [1:0] addr = 2'd0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out, v;
  logic tx, irq, prev_irq;
  int total = 0, bad = 0;
  bit found;

  uart_tx_port #(.BAUD_DIV(4), .FIFO_AW(3)) dut (
    .clk(clk), .reset(reset), .sel(sel), .addr(addr), .we(we),
    .data_in(data_in), .data_out(data_out), .tx(tx), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    sel = 1'b1; we = 1'b1; addr = a; data_in = d;
    @(negedge clk);
    sel = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [7:0] r);
    sel = 1'b1; we = 1'b0; addr = a;
    @(negedge clk);
    sel = 1'b0;
    r = data_out;
  endtask

  task automatic wait_idle(input string tag);
    found = 1'b0;
    prev_irq = irq;
    for (int k = 0; k < 800 && !found; k++) begin
      rd(2'd1, v);
      if (v == 8'h04) found = 1'b1; else prev_irq = irq;
    end
    chk({tag, "_idle_reached"}, {7'b0, found}, 8'h01);
  endtask

  initial begin
    logic [9:0] fr, fr2;
    repeat (3) @(negedge clk);
    chk("rst_tx", {7'b0, tx}, 8'h01);
    chk("rst_irq", {7'b0, irq}, 8'h00);
    chk("rst_dout", data_out, 8'h00);
    reset = 1'b1;
    @(negedge clk);
    rd(2'd1, v);
    chk("status_after_rst", v, 8'h04);

    // single frame 0xA5, sampled once per clock
    fr = {1'b1, 8'hA5, 1'b0};
    wr(2'd0, 8'hA5);
    @(negedge clk);
    chk("tx_idle_at_pop", {7'b0, tx}, 8'h01);
    for (int i = 0; i < 40; i++) begin
      if (i == 20) begin sel = 1'b1; we = 1'b0; addr = 2'd1; end
      @(negedge clk);
      sel = 1'b0;
      chk($sformatf("a5_bit%0d_clk%0d", i / 4, i % 4), {7'b0, tx}, {7'b0, fr[i/4]});
      if (i == 20) chk("a5_status_busy", data_out, 8'h05);
    end
    rd(2'd1, v);
    chk("a5_status_after", v, 8'h04);
    chk("a5_tx_after", {7'b0, tx}, 8'h01);

    // async reset during data bit 3 of 0xF0 (bit 3 is 0)
    wr(2'd0, 8'hF0);
    repeat (1 + 17) @(negedge clk);
    chk("f0_bit3_low", {7'b0, tx}, 8'h00);
    #2 reset = 1'b0;
    #1 chk("async_rst_tx", {7'b0, tx}, 8'h01);
    chk("async_rst_irq", {7'b0, irq}, 8'h00);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("async_rst_tx_hold", {7'b0, tx}, 8'h01);
    rd(2'd1, v);
    chk("status_after_async_rst", v, 8'h04);
    chk("irq_after_async_rst", {7'b0, irq}, 8'h00);

    // overflow: 9 bytes fit (1 in engine + 8 in FIFO), the 10th is dropped
    for (int b = 0; b < 9; b++) wr(2'd0, 8'(b));
    rd(2'd1, v);
    chk("nine_full_no_ovf", v, 8'h03);
    wr(2'd0, 8'h09);
    rd(2'd1, v);
    chk("ovf_first_read", v, 8'h0B);
    rd(2'd1, v);
    chk("ovf_cleared", v, 8'h03);

    // CTRL and back-to-back read addresses
    wr(2'd2, 8'hFF);
    sel = 1'b1; we = 1'b0; addr = 2'd1;
    @(negedge clk);
    chk("rd_n_status", data_out, 8'h03);
    addr = 2'd2;
    @(negedge clk);
    chk("rd_n1_ctrl", data_out, 8'h01);
    addr = 2'd3;
    @(negedge clk);
    chk("rd_reserved", data_out, 8'h00);
    addr = 2'd0;
    @(negedge clk);
    sel = 1'b0;
    chk("rd_data_reg", data_out, 8'h00);
    wr(2'd3, 8'hFF);
    rd(2'd3, v);
    chk("reserved_write_ignored", v, 8'h00);
    chk("irq_low_while_busy", {7'b0, irq}, 8'h00);

    // drain; irq rises on the edge after busy falls
    wait_idle("drain");
    chk("irq_prev_low", {7'b0, prev_irq}, 8'h00);
    chk("irq_high", {7'b0, irq}, 8'h01);
    wr(2'd0, 8'h11);
    chk("irq_lags_push", {7'b0, irq}, 8'h01);
    @(negedge clk);
    chk("irq_fell", {7'b0, irq}, 8'h00);
    wait_idle("after_11");
    chk("irq_back", {7'b0, irq}, 8'h01);

    // back-to-back frames: one idle clock between them
    fr = {1'b1, 8'h55, 1'b0};
    fr2 = {1'b1, 8'h33, 1'b0};
    wr(2'd0, 8'h55);
    wr(2'd0, 8'h33);
    chk("b2b_tx_pre", {7'b0, tx}, 8'h01);
    for (int i = 0; i < 82; i++) begin
      @(negedge clk);
      chk($sformatf("b2b_clk%0d", i), {7'b0, tx},
          {7'b0, i < 40 ? fr[i/4] : i == 40 ? 1'b1 : i < 81 ? fr2[(i-41)/4] : 1'b1});
    end
    wait_idle("b2b");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
